// File: rtl/can_tx_arbiter.sv
// can_tx_arbiter: round-robin scheduler sharing one can_controller transmit path between NREQ requesters.
// Optional CAN_ARB_TIMEOUT_EN builds a per-transfer watchdog and ERR state.
module can_tx_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
`ifdef CAN_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 65535
`endif
) (
  input  logic                  GCLK,
  input  logic                  RES,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  output logic                  busy,
  output logic [IDW-1:0]        gnt_id,
  output logic [WIDTH-1:0]      can_din,
  output logic                  can_tx_start,
  input  logic                  can_tx_ready
);
`ifdef CAN_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, START, XMIT, DONE, ERR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic expired;
  assign expired = cnt == CW'(TIMEOUT - 1);
`else
  typedef enum logic [1:0] {IDLE, START, XMIT, DONE} state_t;
`endif
  state_t state, state_n;
  logic [IDW-1:0] last, win, idx;
  logic [WIDTH-1:0] slot [NREQ];
  logic grant;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot[g] = din[g*WIDTH +: WIDTH];
  end

  // Highest offset first so the nearest set bit after last wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(last) + i) % NREQ);
      win = req[idx] ? idx : win;
    end
  end

  assign grant = state == IDLE && |req && can_tx_ready;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = grant ? START : IDLE;
      START:   state_n = can_tx_ready ? START : XMIT;
      XMIT:    state_n = can_tx_ready ? DONE : XMIT;
      default: state_n = IDLE;
    endcase
`ifdef CAN_ARB_TIMEOUT_EN
    if ((state == START || state == XMIT) && expired) state_n = ERR;
`endif
  end

  always_ff @(posedge GCLK) begin
    if (RES) begin
      state        <= IDLE;
      last         <= IDW'(NREQ - 1);
      gnt_id       <= '0;
      can_din      <= '0;
      can_tx_start <= 1'b0;
      ack          <= '0;
      err          <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      last         <= (state != IDLE && state_n == IDLE) ? gnt_id : last;
      gnt_id       <= grant ? win : gnt_id;
      can_din      <= grant ? slot[win] : can_din;
      can_tx_start <= state_n == START;
      ack          <= state_n == DONE ? NREQ'(1) << gnt_id : '0;
`ifdef CAN_ARB_TIMEOUT_EN
      err          <= state_n == ERR ? NREQ'(1) << gnt_id : '0;
`else
      err          <= '0;
`endif
      busy         <= state_n != IDLE;
    end
  end

`ifdef CAN_ARB_TIMEOUT_EN
  always_ff @(posedge GCLK) begin
    if (RES) cnt <= '0;
    else cnt <= grant ? '0 : (state == START || state == XMIT) ? cnt + 1'b1 : cnt;
  end
`endif
endmodule

// File: tb/tb_can_tx_arbiter.sv
// tb_can_tx_arbiter: vector table, corner sequences and randomized transfers checked against
// a transaction-level round-robin model, with a behavioural can_controller handshake model.
module tb_can_tx_arbiter;
  localparam int WIDTH = 32, NREQ = 4, IDW = 2;
  logic GCLK = 1'b0, RES = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*WIDTH-1:0] din = '0;
  logic [NREQ-1:0] ack, err;
  logic busy, can_tx_start, can_tx_ready;
  logic [IDW-1:0] gnt_id;
  logic [WIDTH-1:0] can_din;
  logic ctl_auto = 1'b1, ready_auto = 1'b1, ready_force = 1'b1;
  int drop_dly = 0, frame_len = 1, ctl_wait = 0;
  int passed = 0, total = 0;

  assign can_tx_ready = ctl_auto ? ready_auto : ready_force;

  can_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)
`ifdef CAN_ARB_TIMEOUT_EN
    , .TIMEOUT(200)
`endif
  ) dut (
    .GCLK(GCLK), .RES(RES), .req(req), .din(din), .ack(ack), .err(err), .busy(busy),
    .gnt_id(gnt_id), .can_din(can_din), .can_tx_start(can_tx_start), .can_tx_ready(can_tx_ready)
  );

  always #5 GCLK = ~GCLK;

  // Controller model: accepts tx_start after drop_dly cycles, frame lasts frame_len cycles.
  initial forever begin
    @(posedge GCLK); #2;
    if (RES) begin
      ready_auto = 1'b1;
      ctl_wait = 0;
    end else if (ctl_auto && ready_auto && can_tx_start) begin
      if (ctl_wait >= drop_dly) begin ready_auto = 1'b0; ctl_wait = 0; end
      else ctl_wait++;
    end else if (ctl_auto && !ready_auto) begin
      if (ctl_wait >= frame_len) begin ready_auto = 1'b1; ctl_wait = 0; end
      else ctl_wait++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge GCLK); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int prev);
    for (int k = 1; k <= NREQ; k++)
      if (r[(prev + k) % NREQ]) return (prev + k) % NREQ;
    return 0;
  endfunction

  task automatic do_reset;
    ctl_auto = 1'b1;
    ready_force = 1'b1;
    req = '0;
    RES = 1'b1;
    tick;
    tick;
    RES = 1'b0;
  endtask

  task automatic run_xfer(input logic [NREQ-1:0] pat, input bit hold, input int exp,
                          input logic [WIDTH-1:0] pl, input int dd, input int fl);
    int n;
    drop_dly = dd;
    frame_len = fl;
    req = pat;
    for (int i = 0; i < NREQ; i++) din[i*WIDTH +: WIDTH] = $urandom();
    din[exp*WIDTH +: WIDTH] = pl;
    tick;
    chk("grant_start", can_tx_start, 1);
    chk("grant_busy", busy, 1);
    chk("grant_id", gnt_id, exp);
    chk("grant_din", can_din, pl);
    for (int i = 0; i < NREQ; i++) din[i*WIDTH +: WIDTH] = $urandom();
    n = 0;
    while (ack == '0 && n < 2000) begin tick; n++; end
    chk("ack_seen", ack != '0, 1);
    chk("ack_onehot", ack, 64'(1) << exp);
    chk("payload_held", can_din, pl);
    chk("err_quiet", err, 0);
    chk("busy_in_done", busy, 1);
    if (!hold) req[exp] = 1'b0;
    tick;
    chk("ack_one_cycle", ack, 0);
    chk("busy_after", busy, 0);
  endtask

  typedef struct { logic [NREQ-1:0] pat; logic [WIDTH-1:0] pl; int dd; int fl; int exp; } vec_t;
  vec_t tbl [8];

  initial begin
    int n, m_last, e;
    logic [NREQ-1:0] pending, pat;
    tbl[0] = '{4'b0010, 32'h0000_4849, 2, 100, 1};
    tbl[1] = '{4'b1111, 32'h1111_0002, 0, 3, 2};
    tbl[2] = '{4'b1011, 32'h2222_0003, 1, 1, 3};
    tbl[3] = '{4'b0011, 32'h3333_0000, 4, 7, 0};
    tbl[4] = '{4'b0101, 32'h4444_0002, 0, 1, 2};
    tbl[5] = '{4'b0011, 32'h5555_0000, 2, 12, 0};
    tbl[6] = '{4'b0010, 32'h6666_0001, 3, 2, 1};
    tbl[7] = '{4'b1001, 32'h7777_0003, 1, 5, 3};

    do_reset;
    chk("rst_start", can_tx_start, 0);
    chk("rst_din", can_din, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);

    foreach (tbl[i]) run_xfer(tbl[i].pat, 1'b0, tbl[i].exp, tbl[i].pl, tbl[i].dd, tbl[i].fl);

    // Fairness with all requests held continuously.
    do_reset;
    foreach (tbl[i]) if (i < 5) run_xfer(4'b1111, 1'b1, i % NREQ, $urandom(), 1, 5);

    // Round-robin pointer after requester 0 is served.
    do_reset;
    run_xfer(4'b0001, 1'b0, 0, 32'hA000_0000, 0, 2);
    run_xfer(4'b0101, 1'b0, 2, 32'hA000_0002, 0, 2);
    run_xfer(4'b0001, 1'b0, 0, 32'hA000_0010, 0, 2);

    // Controller busy in IDLE holds off the grant.
    do_reset;
    ctl_auto = 1'b0;
    ready_force = 1'b0;
    req = 4'b1000;
    din[3*WIDTH +: WIDTH] = 32'hCAFE_0003;
    repeat (5) begin
      tick;
      chk("ctlbusy_no_start", can_tx_start, 0);
      chk("ctlbusy_idle", busy, 0);
    end
    ready_force = 1'b1;
    tick;
    chk("ctlbusy_start", can_tx_start, 1);
    chk("ctlbusy_gnt", gnt_id, 3);
    chk("ctlbusy_din", can_din, 32'hCAFE_0003);
    ready_force = 1'b0;
    tick;
    ready_force = 1'b1;
    tick;
    chk("ctlbusy_ack", ack, 4'b1000);
    req = '0;
    tick;

    // Reset while in XMIT aborts the frame silently.
    do_reset;
    ctl_auto = 1'b0;
    ready_force = 1'b1;
    req = 4'b0010;
    tick;
    chk("abort_gnt", gnt_id, 1);
    ready_force = 1'b0;
    tick;
    tick;
    chk("abort_in_xmit", {busy, can_tx_start}, 2'b10);
    req = 4'b0011;
    RES = 1'b1;
    tick;
    RES = 1'b0;
    ready_force = 1'b1;
    chk("abort_start", can_tx_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    chk("abort_err", err, 0);
    tick;
    chk("abort_regrant", gnt_id, 0);
    chk("abort_regrant_start", can_tx_start, 1);
    ready_force = 1'b0;
    tick;
    ready_force = 1'b1;
    tick;
    chk("abort_ack_req0", ack, 4'b0001);
    req = '0;
    tick;

`ifdef CAN_ARB_TIMEOUT_EN
    // Controller never accepts: watchdog fires TIMEOUT cycles after grant.
    do_reset;
    ctl_auto = 1'b0;
    ready_force = 1'b1;
    req = 4'b0011;
    tick;
    chk("to_gnt", gnt_id, 0);
    n = 0;
    while (err == '0 && n < 400) begin tick; n++; end
    chk("to_cycles", n, 200);
    chk("to_err", err, 4'b0001);
    chk("to_start_low", can_tx_start, 0);
    chk("to_no_ack", ack, 0);
    req = 4'b0010;
    tick;
    chk("to_err_once", err, 0);
    tick;
    chk("to_next_gnt", gnt_id, 1);
    chk("to_next_start", can_tx_start, 1);
`endif

    // Randomized transfers against the round-robin model.
    do_reset;
    m_last = NREQ - 1;
    pending = '0;
    for (int t = 0; t < 40; t++) begin
      pat = pending | NREQ'($urandom_range(0, 15));
      if (pat == '0) pat[$urandom_range(0, NREQ - 1)] = 1'b1;
      e = rr_pick(pat, m_last);
      run_xfer(pat, 1'b0, e, $urandom(), $urandom_range(0, 4), $urandom_range(1, 20));
      pending = pat & ~(NREQ'(1) << e);
      m_last = e;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
